// File: rtl/uart_tx_engine_if.sv
// Word-offer bus between a producer and the UART transmit engine.
// Carries the data word, its frame configuration and the Ready handshake.
interface uart_tx_engine_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  Ready;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  STOP2;
   logic [PRESCALE_W-1:0] Prescale;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, Prescale,
      input  Ready
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, Prescale,
      output Ready
   );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one latched word per frame (start, data LSB first,
// optional parity, one or two stop bits) with a programmable clocks-per-bit prescale.
module uart_tx_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic            CLK,
   input  logic            RST,
   uart_tx_engine_if.slave txIf,
   output logic            TX_OUT,
   output logic            busy,
   output logic            frame_done
);
   localparam int IDX_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP1   = 3'd4,
      STOP2_S = 3'd5
   } stateT;

   stateT                 state_q, state_d;
   logic [PRESCALE_W-1:0] bitCnt_q, bitCnt_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] bitLast;
   logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] dataShift;
   logic                  parEn_q, parEn_d;
   logic                  parTyp_q, parTyp_d;
   logic                  stop2_q, stop2_d;
   logic                  txOut_q, txOut_d;
   logic                  bitWrap;
   logic                  lastStop;
   logic                  accept;

   // A latched prescale of zero behaves as one clock per bit.
   assign bitLast  = (prescale_q == '0) ? '0 : prescale_q - 1'b1;
   assign bitWrap  = (bitCnt_q == bitLast);
   assign lastStop = bitWrap && (((state_q == STOP1) && !stop2_q) || (state_q == STOP2_S));

   // Ready is masked while reset is held so nothing can be accepted mid-reset.
   assign txIf.Ready = !RST && ((state_q == IDLE) || lastStop);
   assign accept     = txIf.Data_Valid && txIf.Ready;
   assign busy       = (state_q != IDLE);
   assign frame_done = lastStop;
   assign TX_OUT     = txOut_q;

   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      bitIdx_d   = bitIdx_q;
      data_d     = data_q;
      parEn_d    = parEn_q;
      parTyp_d   = parTyp_q;
      stop2_d    = stop2_q;
      prescale_d = prescale_q;
      txOut_d    = 1'b1;
      dataShift  = '0;

      if (state_q != IDLE) begin
         bitCnt_d = bitWrap ? '0 : bitCnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
         end
         START: begin
            if (bitWrap) begin
               state_d  = DATA;
               bitIdx_d = '0;
            end
         end
         DATA: begin
            if (bitWrap) begin
               if (bitIdx_q == IDX_W'(DATA_WIDTH - 1)) begin
                  state_d = parEn_q ? PARITY : STOP1;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bitWrap) begin
               state_d = STOP1;
            end
         end
         STOP1: begin
            if (bitWrap) begin
               state_d = stop2_q ? STOP2_S : IDLE;
            end
         end
         STOP2_S: begin
            if (bitWrap) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            bitCnt_d = '0;
            bitIdx_d = '0;
         end
      endcase

      // Accepting on the final stop clock overrides the return to IDLE, giving gapless frames.
      if (accept) begin
         state_d    = START;
         bitCnt_d   = '0;
         bitIdx_d   = '0;
         data_d     = txIf.P_DATA;
         parEn_d    = txIf.PAR_EN;
         parTyp_d   = txIf.PAR_TYP;
         stop2_d    = txIf.STOP2;
         prescale_d = txIf.Prescale;
      end

      dataShift = data_d >> bitIdx_d;
      case (state_d)
         START:   txOut_d = 1'b0;
         DATA:    txOut_d = dataShift[0];
         PARITY:  txOut_d = (^data_d) ^ parTyp_d;
         default: txOut_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         bitIdx_q   <= '0;
         data_q     <= '0;
         parEn_q    <= 1'b0;
         parTyp_q   <= 1'b0;
         stop2_q    <= 1'b0;
         prescale_q <= '0;
         txOut_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         bitIdx_q   <= bitIdx_d;
         data_q     <= data_d;
         parEn_q    <= parEn_d;
         parTyp_q   <= parTyp_d;
         stop2_q    <= stop2_d;
         prescale_q <= prescale_d;
         txOut_q    <= txOut_d;
      end
   end
endmodule
